// File: rtl/dm_top_if.sv
// Request/response bundle between the sequencer/DAG/bus controller and the data-memory stage.
interface dm_top_if #(
    parameter int unsigned DW = 16
) ();
    logic          ps_dm_en;
    logic          ps_dm_wrt;
    logic [DW-1:0] dg_dm_add;
    logic [DW-1:0] bc_dt;
    logic          ps_dm_err_clr;
    logic [DW-1:0] dm_bc_dt;
    logic          dm_rd_vld;
    logic          dm_ps_stall;
    logic          dm_err;

    modport master (
        output ps_dm_en,
        output ps_dm_wrt,
        output dg_dm_add,
        output bc_dt,
        output ps_dm_err_clr,
        input  dm_bc_dt,
        input  dm_rd_vld,
        input  dm_ps_stall,
        input  dm_err
    );

    modport slave (
        input  ps_dm_en,
        input  ps_dm_wrt,
        input  dg_dm_add,
        input  bc_dt,
        input  ps_dm_err_clr,
        output dm_bc_dt,
        output dm_rd_vld,
        output dm_ps_stall,
        output dm_err
    );
endinterface

// File: rtl/dm_top.sv
// Data-memory stage: one single-port SRAM access per accepted request, with a
// programmable number of wait states, sticky out-of-range error and sequencer stall.
module dm_top #(
    parameter int unsigned DW          = 16,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic    clk,
    input  logic    reset,
    dm_top_if.slave bus
);
    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WsInit = 4'(WAIT_STATES);
    localparam bit          NoWait = (WAIT_STATES == 0);

    typedef enum logic [1:0] {StIdle, StWait, StAccess} state_e;

    state_e        r_state;
    state_e        w_state_d;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_d;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          r_wrt;
    logic          r_oor;
    logic [DW-1:0] r_rd_dt;
    logic          r_rd_vld;
    logic          r_err;
    logic [DW-1:0] r_mem [DEPTH];

    logic w_accept;
    logic w_oor;
    logic w_access;
    logic w_do_wr;
    logic w_do_rd;

    // Out-of-range means any address bit above the memory index is set.
    generate
        if (DW > AW) begin : g_oor
            assign w_oor = |bus.dg_dm_add[DW-1:AW];
        end else begin : g_no_oor
            assign w_oor = 1'b0;
        end
    endgenerate

    assign w_accept = (r_state == StIdle) && bus.ps_dm_en;
    assign w_access = (r_state == StAccess);
    assign w_do_wr  = w_access && r_wrt && !r_oor;
    assign w_do_rd  = w_access && !r_wrt;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (bus.ps_dm_en) begin
                    if (NoWait) begin
                        w_state_d = StAccess;
                    end else begin
                        w_state_d = StWait;
                        w_cnt_d   = WsInit;
                    end
                end
            end
            StWait: begin
                w_cnt_d = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_d = StAccess;
                end
            end
            StAccess: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_cnt    <= 4'd0;
            r_addr   <= '0;
            r_data   <= '0;
            r_wrt    <= 1'b0;
            r_oor    <= 1'b0;
            r_rd_dt  <= '0;
            r_rd_vld <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_rd_vld <= w_do_rd;
            if (w_accept) begin
                r_addr <= bus.dg_dm_add[AW-1:0];
                r_data <= bus.bc_dt;
                r_wrt  <= bus.ps_dm_wrt;
                r_oor  <= w_oor;
            end
            if (w_do_rd) begin
                r_rd_dt <= r_oor ? '0 : r_mem[r_addr];
            end
            // A new error at the same edge as a clear takes priority.
            if (w_access && r_oor) begin
                r_err <= 1'b1;
            end else if (bus.ps_dm_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // Storage is not reset; an aborted access never reaches StAccess.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_addr] <= r_data;
        end
    end

    assign bus.dm_bc_dt    = r_rd_dt;
    assign bus.dm_rd_vld   = r_rd_vld;
    assign bus.dm_ps_stall = (r_state != StIdle);
    assign bus.dm_err      = r_err;
endmodule

// File: tb/tb_dm_top.sv
// Self-checking bench for dm_top: one instance with one wait state, one with none.
module tb_dm_top;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_top_if #(.DW(16)) if_ws1 ();
    dm_top_if #(.DW(16)) if_ws0 ();

    dm_top #(.DW(16), .DEPTH(256), .WAIT_STATES(1)) u_dut_ws1 (
        .clk(clk), .reset(reset), .bus(if_ws1)
    );
    dm_top #(.DW(16), .DEPTH(256), .WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .reset(reset), .bus(if_ws0)
    );

    // Reference model, index 1 = one-wait-state instance, 0 = zero-wait instance.
    logic [15:0] m_mem   [2][256];
    bit          m_known [2][256];
    logic [15:0] m_rd    [2];
    bit          m_err   [2];

    task automatic model_acc(input bit sel, input bit wrt, input logic [15:0] addr,
                             input logic [15:0] data);
        bit oor;
        oor = (int'(addr) >= 256);
        if (wrt) begin
            if (!oor) begin
                m_mem[sel][addr]   = data;
                m_known[sel][addr] = 1'b1;
            end
        end else begin
            m_rd[sel] = oor ? 16'h0000 : m_mem[sel][addr];
        end
        if (oor) m_err[sel] = 1'b1;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_rd[s]  = 16'h0000;
            m_err[s] = 1'b0;
        end
    endtask

    task automatic set_req(input bit sel, input logic en, input logic wrt,
                           input logic [15:0] addr, input logic [15:0] data);
        if (sel) begin
            if_ws1.ps_dm_en = en; if_ws1.ps_dm_wrt = wrt;
            if_ws1.dg_dm_add = addr; if_ws1.bc_dt = data;
        end else begin
            if_ws0.ps_dm_en = en; if_ws0.ps_dm_wrt = wrt;
            if_ws0.dg_dm_add = addr; if_ws0.bc_dt = data;
        end
    endtask

    task automatic set_clr(input bit sel, input logic c);
        if (sel) if_ws1.ps_dm_err_clr = c;
        else     if_ws0.ps_dm_err_clr = c;
    endtask

    task automatic idle(input bit sel);
        set_req(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    function automatic logic get_stall(input bit sel);
        return sel ? if_ws1.dm_ps_stall : if_ws0.dm_ps_stall;
    endfunction
    function automatic logic get_vld(input bit sel);
        return sel ? if_ws1.dm_rd_vld : if_ws0.dm_rd_vld;
    endfunction
    function automatic logic [15:0] get_dt(input bit sel);
        return sel ? if_ws1.dm_bc_dt : if_ws0.dm_bc_dt;
    endfunction
    function automatic logic get_err(input bit sel);
        return sel ? if_ws1.dm_err : if_ws0.dm_err;
    endfunction

    // Issue one request at the current negedge, scramble inputs while stalled, and
    // return at the negedge of the first non-stalled cycle.
    task automatic do_acc(input bit sel, input bit wrt, input logic [15:0] addr,
                          input logic [15:0] data, input bit hold, input bit clr_acc,
                          output int stall_n, output bit vld_early, output bit dt_moved,
                          output int acc_cyc);
        logic [15:0] dt0;
        stall_n   = 0;
        vld_early = 1'b0;
        dt_moved  = 1'b0;
        dt0       = get_dt(sel);
        set_req(sel, 1'b1, wrt, addr, data);
        acc_cyc = cyc;
        @(negedge clk);
        while (get_stall(sel) && stall_n < 40) begin
            stall_n++;
            if (get_vld(sel)) vld_early = 1'b1;
            if (get_dt(sel) !== dt0) dt_moved = 1'b1;
            set_req(sel, hold ? 1'b1 : 1'($urandom), 1'($urandom), 16'($urandom),
                    16'($urandom));
            if (clr_acc) set_clr(sel, 1'b1);
            @(negedge clk);
        end
        set_clr(sel, 1'b0);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (get_stall(1'(s)) !== 1'b0 || get_vld(1'(s)) !== 1'b0 ||
                get_dt(1'(s)) !== 16'h0000 || get_err(1'(s)) !== 1'b0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got stall=%b vld=%b dt=%h err=%b, want 0 0 0000 0",
                         s, get_stall(1'(s)), get_vld(1'(s)), get_dt(1'(s)), get_err(1'(s)));
            end
        end
    endtask

    task automatic test_basic();
        int sn, ac; bit ve, dm;
        do_acc(1'b1, 1'b1, 16'h00A5, 16'h1234, 1'b0, 1'b0, sn, ve, dm, ac);
        model_acc(1'b1, 1'b1, 16'h00A5, 16'h1234);
        checks++;
        if (sn != 2 || ve || get_vld(1'b1) !== 1'b0 || get_err(1'b1) !== 1'b0) begin
            errors++;
            $display("FAIL basic_write: got stall_cycles=%0d vld=%b err=%b, want 2 0 0",
                     sn, get_vld(1'b1), get_err(1'b1));
        end
        do_acc(1'b1, 1'b0, 16'h00A5, 16'h0000, 1'b0, 1'b0, sn, ve, dm, ac);
        model_acc(1'b1, 1'b0, 16'h00A5, 16'h0000);
        idle(1'b1);
        checks++;
        if (sn != 2 || ve || get_vld(1'b1) !== 1'b1 || get_dt(1'b1) !== 16'h1234) begin
            errors++;
            $display("FAIL basic_read: got stall_cycles=%0d vld=%b dt=%h, want 2 1 1234",
                     sn, get_vld(1'b1), get_dt(1'b1));
        end
        @(negedge clk);
        checks++;
        if (get_vld(1'b1) !== 1'b0 || get_err(1'b1) !== 1'b0) begin
            errors++;
            $display("FAIL basic_vld_pulse: got vld=%b err=%b, want 0 0",
                     get_vld(1'b1), get_err(1'b1));
        end
    endtask

    task automatic test_back_to_back();
        int sn, ac, prev; bit ve, dm;
        logic [15:0] exp_v [3] = '{16'h1111, 16'h2222, 16'h3333};
        for (int i = 0; i < 3; i++) begin
            do_acc(1'b1, 1'b1, 16'(i + 1), exp_v[i], 1'b0, 1'b0, sn, ve, dm, ac);
            model_acc(1'b1, 1'b1, 16'(i + 1), exp_v[i]);
        end
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            do_acc(1'b1, 1'b0, 16'(i + 1), 16'h0000, 1'b1, 1'b0, sn, ve, dm, ac);
            model_acc(1'b1, 1'b0, 16'(i + 1), 16'h0000);
            checks++;
            if (get_vld(1'b1) !== 1'b1 || get_dt(1'b1) !== exp_v[i] || dm) begin
                errors++;
                $display("FAIL b2b_read%0d: got vld=%b dt=%h moved=%b, want 1 %h 0",
                         i, get_vld(1'b1), get_dt(1'b1), dm, exp_v[i]);
            end
            if (i > 0) begin
                checks++;
                if (ac - prev != 3) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: got %0d cycles, want 3", i, ac - prev);
                end
            end
            prev = ac;
        end
        idle(1'b1);
        @(negedge clk);
    endtask

    task automatic test_oor();
        int sn, ac; bit ve, dm;
        logic [15:0] pre;
        pre = 16'($urandom);
        do_acc(1'b1, 1'b1, 16'h0000, pre, 1'b0, 1'b0, sn, ve, dm, ac);
        model_acc(1'b1, 1'b1, 16'h0000, pre);
        do_acc(1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b1, sn, ve, dm, ac);
        model_acc(1'b1, 1'b0, 16'h0100, 16'h0000);
        checks++;
        if (sn != 2 || get_vld(1'b1) !== 1'b1 || get_dt(1'b1) !== 16'h0000 ||
            get_err(1'b1) !== 1'b1) begin
            errors++;
            $display("FAIL oor_read: got stall_cycles=%0d vld=%b dt=%h err=%b, want 2 1 0000 1",
                     sn, get_vld(1'b1), get_dt(1'b1), get_err(1'b1));
        end
        do_acc(1'b1, 1'b1, 16'h0100, 16'hFFFF, 1'b0, 1'b0, sn, ve, dm, ac);
        model_acc(1'b1, 1'b1, 16'h0100, 16'hFFFF);
        checks++;
        if (sn != 2 || get_err(1'b1) !== 1'b1) begin
            errors++;
            $display("FAIL oor_write: got stall_cycles=%0d err=%b, want 2 1", sn, get_err(1'b1));
        end
        do_acc(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, sn, ve, dm, ac);
        model_acc(1'b1, 1'b0, 16'h0000, 16'h0000);
        idle(1'b1);
        checks++;
        if (get_dt(1'b1) !== pre) begin
            errors++;
            $display("FAIL oor_mem0: got %h want %h", get_dt(1'b1), pre);
        end
        set_clr(1'b1, 1'b1);
        @(negedge clk);
        set_clr(1'b1, 1'b0);
        m_err[1] = 1'b0;
        checks++;
        if (get_err(1'b1) !== 1'b0) begin
            errors++;
            $display("FAIL oor_clear: got err=%b want 0", get_err(1'b1));
        end
    endtask

    task automatic test_reset_abort();
        int sn, ac; bit ve, dm;
        do_acc(1'b1, 1'b1, 16'h0010, 16'h5555, 1'b0, 1'b0, sn, ve, dm, ac);
        model_acc(1'b1, 1'b1, 16'h0010, 16'h5555);
        set_req(1'b1, 1'b1, 1'b1, 16'h0010, 16'hAAAA);
        @(negedge clk);
        idle(1'b1);
        checks++;
        if (get_stall(1'b1) !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_stall: got %b want 1", get_stall(1'b1));
        end
        reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (get_stall(1'b1) !== 1'b0 || get_vld(1'b1) !== 1'b0 || get_dt(1'b1) !== 16'h0000) begin
            errors++;
            $display("FAIL abort_outputs: got stall=%b vld=%b dt=%h, want 0 0 0000",
                     get_stall(1'b1), get_vld(1'b1), get_dt(1'b1));
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_acc(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, sn, ve, dm, ac);
        model_acc(1'b1, 1'b0, 16'h0010, 16'h0000);
        idle(1'b1);
        checks++;
        if (get_vld(1'b1) !== 1'b1 || get_dt(1'b1) !== 16'h5555) begin
            errors++;
            $display("FAIL abort_mem_kept: got vld=%b dt=%h, want 1 5555",
                     get_vld(1'b1), get_dt(1'b1));
        end
    endtask

    task automatic test_ws0();
        int sn, ac, prev; bit ve, dm;
        logic [15:0] a;
        a = 16'($urandom_range(0, 255));
        do_acc(1'b0, 1'b1, a, 16'hBEEF, 1'b0, 1'b0, sn, ve, dm, ac);
        model_acc(1'b0, 1'b1, a, 16'hBEEF);
        checks++;
        if (sn != 1 || get_vld(1'b0) !== 1'b0) begin
            errors++;
            $display("FAIL ws0_write: got stall_cycles=%0d vld=%b, want 1 0", sn, get_vld(1'b0));
        end
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            do_acc(1'b0, 1'b0, a, 16'h0000, 1'b1, 1'b0, sn, ve, dm, ac);
            model_acc(1'b0, 1'b0, a, 16'h0000);
            checks++;
            if (sn != 1 || ve || get_vld(1'b0) !== 1'b1 || get_dt(1'b0) !== 16'hBEEF) begin
                errors++;
                $display("FAIL ws0_read%0d: got stall_cycles=%0d vld=%b dt=%h, want 1 1 beef",
                         i, sn, get_vld(1'b0), get_dt(1'b0));
            end
            if (i > 0) begin
                checks++;
                if (ac - prev != 2) begin
                    errors++;
                    $display("FAIL ws0_spacing%0d: got %0d cycles, want 2", i, ac - prev);
                end
            end
            prev = ac;
        end
        idle(1'b0);
        @(negedge clk);
    endtask

    task automatic test_hold_data();
        int sn, ac; bit ve, dm;
        do_acc(1'b1, 1'b1, 16'h0008, 16'h0000, 1'b0, 1'b0, sn, ve, dm, ac);
        model_acc(1'b1, 1'b1, 16'h0008, 16'h0000);
        do_acc(1'b1, 1'b0, 16'h00A5, 16'h0000, 1'b0, 1'b0, sn, ve, dm, ac);
        model_acc(1'b1, 1'b0, 16'h00A5, 16'h0000);
        do_acc(1'b1, 1'b1, 16'h0007, 16'h0C0C, 1'b0, 1'b0, sn, ve, dm, ac);
        model_acc(1'b1, 1'b1, 16'h0007, 16'h0C0C);
        checks++;
        if (dm || get_dt(1'b1) !== 16'h1234 || get_vld(1'b1) !== 1'b0) begin
            errors++;
            $display("FAIL hold_during_write: got dt=%h vld=%b moved=%b, want 1234 0 0",
                     get_dt(1'b1), get_vld(1'b1), dm);
        end
        do_acc(1'b1, 1'b0, 16'h0008, 16'h0000, 1'b0, 1'b0, sn, ve, dm, ac);
        model_acc(1'b1, 1'b0, 16'h0008, 16'h0000);
        idle(1'b1);
        checks++;
        if (dm || get_dt(1'b1) !== 16'h0000 || get_vld(1'b1) !== 1'b1) begin
            errors++;
            $display("FAIL hold_read_update: got dt=%h vld=%b moved=%b, want 0000 1 0",
                     get_dt(1'b1), get_vld(1'b1), dm);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int sn, ac, ws; bit ve, dm, wrt;
        logic [15:0] a, d;
        for (int s = 0; s < 2; s++) begin
            ws = s;
            for (int n = 0; n < 40; n++) begin
                if ($urandom_range(0, 7) == 0) begin
                    a = 16'($urandom_range(256, 65535));
                end else begin
                    a = 16'($urandom_range(0, 255));
                end
                d   = 16'($urandom);
                wrt = 1'($urandom);
                if (!wrt && int'(a) < 256 && !m_known[s][a]) wrt = 1'b1;
                do_acc(1'(s), wrt, a, d, 1'($urandom), 1'b0, sn, ve, dm, ac);
                model_acc(1'(s), wrt, a, d);
                checks++;
                if (sn != ws + 1 || ve || dm || get_vld(1'(s)) !== !wrt ||
                    get_dt(1'(s)) !== m_rd[s] || get_err(1'(s)) !== m_err[s]) begin
                    errors++;
                    $display("FAIL rand[%0d.%0d] wrt=%b a=%h: got stall=%0d early=%b moved=%b vld=%b dt=%h err=%b, want %0d 0 0 %b %h %b",
                             s, n, wrt, a, sn, ve, dm, get_vld(1'(s)), get_dt(1'(s)),
                             get_err(1'(s)), ws + 1, !wrt, m_rd[s], m_err[s]);
                end
                if ($urandom_range(0, 1) == 0) begin
                    idle(1'(s));
                    if ($urandom_range(0, 3) == 0) begin
                        set_clr(1'(s), 1'b1);
                        m_err[s] = 1'b0;
                    end
                    @(negedge clk);
                    set_clr(1'(s), 1'b0);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            idle(1'(s));
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle(1'b0);
        idle(1'b1);
        set_clr(1'b0, 1'b0);
        set_clr(1'b1, 1'b0);
        model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) begin
                m_mem[s][i]   = 16'h0000;
                m_known[s][i] = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_basic();
        test_back_to_back();
        test_oor();
        test_reset_abort();
        test_ws0();
        test_hold_data();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end
endmodule
